// File: rtl/miriscv_uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM with
// optional parity and 1/2 stop bits, show-ahead receive FIFO and sticky
// parity / framing / overrun flags.
module miriscv_uart_rx #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUDRATE    = 6250000,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic                          uart_rx_i,
    output logic [DATA_BITS-1:0]          data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    input  logic                          err_clr_i,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUDRATE;
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] HALF_BIT    = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] FULL_BIT_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP   = 4'(STOP_BITS - 1);
    localparam logic          ODD_PARITY  = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // Synchronizer and edge detection
    logic [1:0] sync_q;
    logic [1:0] vld_q;      // marks when sync_q[1] reflects the real line
    logic       rx_prev_q;
    logic       rx_prev_d;
    logic       rx;
    logic       fall;

    // Receiver FSM state
    state_e                state_q,   state_d;
    logic [TW-1:0]         timer_q,   timer_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q,   shift_d;
    logic                  par_bad_q, par_bad_d;
    logic                  frm_bad_q, frm_bad_d;
    logic                  wr_q,      wr_d;
    logic [DATA_BITS-1:0]  wr_data_q, wr_data_d;
    logic                  par_ev_q,  par_ev_d;
    logic                  frm_ev_q,  frm_ev_d;
    logic                  tick;
    logic                  stop_bad_now;

    // FIFO and flags
    logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q,  ovr_d;
    logic                  empty, full, pop, do_push, ovr_ev;

    assign rx        = sync_q[1];
    // A falling edge only counts once the line has been seen high after reset.
    assign fall      = vld_q[1] & rx_prev_q & ~rx;
    assign rx_prev_d = vld_q[1] ? rx : 1'b0;
    assign tick      = (timer_q == '0);
    assign stop_bad_now = frm_bad_q | ~rx;

    // Two-flop synchronizer (resets to idle-high) plus start-edge history
    always_ff @(posedge clk_i or negedge arstn_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!arstn_i) begin
            sync_q    <= 2'b11;
            vld_q     <= 2'b00;
            rx_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], uart_rx_i};
            vld_q     <= {vld_q[0], 1'b1};
            rx_prev_q <= rx_prev_d;
        end
    end

    // Next-state logic for the receiver FSM and its shared counters
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        frm_bad_d = frm_bad_q;
        wr_d      = 1'b0;
        wr_data_d = wr_data_q;
        par_ev_d  = 1'b0;
        frm_ev_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d   = S_START;
                    timer_d   = HALF_BIT;
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
                    frm_bad_d = 1'b0;
                end
            end
            S_START: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else if (rx) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    timer_d = FULL_BIT_M1;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    shift_d = {rx, shift_q[DATA_BITS-1:1]};
                    timer_d = FULL_BIT_M1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    par_bad_d = (rx != ((^shift_q) ^ ODD_PARITY));
                    timer_d   = FULL_BIT_M1;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else if (bit_cnt_q == LAST_STOP) begin
                    // Back to idle right away so the next start edge is not missed.
                    state_d   = S_IDLE;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    wr_d      = ~par_bad_q & ~stop_bad_now;
                    wr_data_d = shift_q;
                    par_ev_d  = par_bad_q;
                    frm_ev_d  = stop_bad_now;
                end else begin
                    frm_bad_d = stop_bad_now;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    timer_d   = FULL_BIT_M1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receiver FSM registers, including the registered write/error strobes
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            frm_bad_q <= 1'b0;
            wr_q      <= 1'b0;
            wr_data_q <= '0;
            par_ev_q  <= 1'b0;
            frm_ev_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            frm_bad_q <= frm_bad_d;
            wr_q      <= wr_d;
            wr_data_q <= wr_data_d;
            par_ev_q  <= par_ev_d;
            frm_ev_q  <= frm_ev_d;
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = ~empty & ready_i;
    assign do_push = wr_q & (~full | pop);
    assign ovr_ev  = wr_q & full & ~pop;

    // FIFO pointer and sticky flag next-state; a set event beats a clear
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        perr_d   = par_ev_q | (perr_q & ~err_clr_i);
        ferr_d   = frm_ev_q | (ferr_q & ~err_clr_i);
        ovr_d    = ovr_ev   | (ovr_q  & ~err_clr_i);
    end

    // FIFO pointers and sticky flags
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    // FIFO storage
    // NOTE: the array has no reset; data_o is masked while empty, so stale contents never show.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_q;
        end
    end

    assign data_o       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o      = ~empty;
    assign level_o      = wr_ptr_q - rd_ptr_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_miriscv_uart_rx.sv
// Self-checking bench for miriscv_uart_rx: directed table, hand-written
// corner sequences and randomized frames against a queue-based model.
module tb_miriscv_uart_rx;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arstn, rx1, rx2, ready, ready2, clr;

    logic [7:0] data1;
    logic       valid1, perr1, ferr1, ovr1;
    logic [3:0] level1;

    logic [6:0] data2;
    logic       valid2, perr2, ferr2, ovr2;
    logic [3:0] level2;

    miriscv_uart_rx u_dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .uart_rx_i    (rx1),
        .data_o       (data1),
        .valid_o      (valid1),
        .ready_i      (ready),
        .err_clr_i    (clr),
        .parity_err_o (perr1),
        .frame_err_o  (ferr1),
        .overrun_o    (ovr1),
        .level_o      (level1)
    );

    miriscv_uart_rx #(
        .DATA_BITS   (7),
        .PARITY_MODE (2),
        .STOP_BITS   (2)
    ) u_dut2 (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .uart_rx_i    (rx2),
        .data_o       (data2),
        .valid_o      (valid2),
        .ready_i      (ready2),
        .err_clr_i    (clr),
        .parity_err_o (perr2),
        .frame_err_o  (ferr2),
        .overrun_o    (ovr2),
        .level_o      (level2)
    );

    int checks = 0;
    int failures = 0;

    // Reference model of the default instance: FIFO contents and sticky flags
    logic [7:0] m_q[$];
    logic       m_perr, m_ferr, m_ovr;

    typedef struct {
        bit         pop_before;
        bit         clr_before;
        logic [7:0] data;
        bit         flip_par;
        bit         bad_stop;
        int         exp_level;
        logic [7:0] exp_head;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input bit which, input logic v);
        if (which) rx2 = v;
        else       rx1 = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic model_clear();
        m_q.delete();
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // 8E1 frame on the default instance; model decides the outcome from the frame contents
    task automatic send1(input logic [7:0] d, input bit flip_par, input bit bad_stop);
        int ones;
        ones = 0;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(1'b0, d[i]);
            ones += int'(d[i]);
        end
        drive_bit(1'b0, logic'(ones % 2) ^ flip_par);
        drive_bit(1'b0, ~bad_stop);
        rx1 = 1'b1;
        if (!flip_par && !bad_stop) begin
            if (m_q.size() < 8) m_q.push_back(d);
            else                m_ovr = 1'b1;
        end else begin
            if (flip_par) m_perr = 1'b1;
            if (bad_stop) m_ferr = 1'b1;
        end
    endtask

    // 7O2 frame on the second instance
    task automatic send2(input logic [6:0] d, input bit flip_par, input bit bad1, input bit bad2);
        int ones;
        ones = 0;
        drive_bit(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive_bit(1'b1, d[i]);
            ones += int'(d[i]);
        end
        drive_bit(1'b1, logic'((ones + 1) % 2) ^ flip_par);
        drive_bit(1'b1, ~bad1);
        drive_bit(1'b1, ~bad2);
        rx2 = 1'b1;
    endtask

    task automatic check_model(input string tag);
        @(negedge clk);
        check({tag, "/level"},  level1, m_q.size());
        check({tag, "/valid"},  valid1, m_q.size() != 0);
        check({tag, "/data"},   data1,  (m_q.size() != 0) ? m_q[0] : 8'h00);
        check({tag, "/perr"},   perr1,  m_perr);
        check({tag, "/ferr"},   ferr1,  m_ferr);
        check({tag, "/ovr"},    ovr1,   m_ovr);
    endtask

    task automatic pop1(input string tag);
        @(negedge clk);
        check({tag, "/pop_valid"}, valid1, m_q.size() != 0);
        check({tag, "/pop_data"},  data1,  (m_q.size() != 0) ? m_q[0] : 8'h00);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
    endtask

    task automatic clear_err();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/level"}, level1, 0);
        check({tag, "/valid"}, valid1, 0);
        check({tag, "/data"},  data1,  0);
        check({tag, "/perr"},  perr1,  0);
        check({tag, "/ferr"},  ferr1,  0);
        check({tag, "/ovr"},   ovr1,   0);
        check({tag, "/valid2"}, valid2, 0);
        check({tag, "/ferr2"},  ferr2,  0);
    endtask

    initial begin
        vecs[0] = '{0, 0, 8'hA5, 0, 0, 1, 8'hA5, 0, 0};
        vecs[1] = '{1, 0, 8'h3C, 1, 0, 0, 8'h00, 1, 0};
        vecs[2] = '{0, 1, 8'h55, 0, 1, 0, 8'h00, 0, 1};
        vecs[3] = '{0, 1, 8'h7E, 0, 0, 1, 8'h7E, 0, 0};
        vecs[4] = '{0, 0, 8'h00, 0, 0, 2, 8'h7E, 0, 0};
        vecs[5] = '{1, 0, 8'h11, 1, 1, 1, 8'h00, 1, 1};
        vecs[6] = '{0, 1, 8'hFF, 0, 0, 2, 8'h00, 0, 0};

        arstn  = 1'b0;
        rx1    = 1'b1;
        rx2    = 1'b1;
        ready  = 1'b0;
        ready2 = 1'b0;
        clr    = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        arstn = 1'b1;
        repeat (5) @(posedge clk);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].pop_before) pop1($sformatf("vec%0d", i));
            if (vecs[i].clr_before) clear_err();
            send1(vecs[i].data, vecs[i].flip_par, vecs[i].bad_stop);
            @(negedge clk);
            check($sformatf("vec%0d/level", i), level1, vecs[i].exp_level);
            check($sformatf("vec%0d/valid", i), valid1, vecs[i].exp_level != 0);
            check($sformatf("vec%0d/data", i),  data1,  vecs[i].exp_head);
            check($sformatf("vec%0d/perr", i),  perr1,  vecs[i].exp_perr);
            check($sformatf("vec%0d/ferr", i),  ferr1,  vecs[i].exp_ferr);
        end

        // Short low glitch on an idle line leaves everything unchanged
        @(posedge clk);
        rx1 = 1'b0;
        repeat (8) @(posedge clk);
        rx1 = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        check_model("glitch");
        send1(8'hC3, 0, 0);
        check_model("after_glitch");

        // Overrun: nine frames with no consumer, then drain
        @(negedge clk);
        arstn = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        for (int i = 0; i < 9; i++) send1(8'(i), 0, 0);
        @(negedge clk);
        check("ovr/level", level1, 8);
        check("ovr/flag",  ovr1,   1);
        check("ovr/head",  data1,  8'h00);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("drain%0d/data", i), data1, 8'(i));
            pop1($sformatf("drain%0d", i));
        end
        pop1("pop_empty");
        check_model("after_drain");
        clear_err();
        check_model("ovr_cleared");

        // Reset in the middle of the data bits, line held low across release
        send1(8'h12, 0, 0);
        send1(8'h34, 1, 0);
        check_model("pre_reset");
        rx1 = 1'b0;
        repeat (CPB + CPB / 2 + 3 * CPB) @(posedge clk);
        #2;
        arstn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        check_model("low_line_ignored");
        rx1 = 1'b1;
        repeat (CPB) @(posedge clk);
        send1(8'h7E, 0, 0);
        check_model("post_reset_7e");
        pop1("post_reset_pop");

        // Seven data bits, odd parity, two stop bits
        send2(7'h41, 0, 0, 0);
        @(negedge clk);
        check("d2/data",  data2,  7'h41);
        check("d2/valid", valid2, 1);
        check("d2/level", level2, 1);
        check("d2/perr",  perr2,  0);
        check("d2/ferr",  ferr2,  0);
        send2(7'h41, 0, 0, 1);
        @(negedge clk);
        check("d2_stop2/ferr",  ferr2,  1);
        check("d2_stop2/level", level2, 1);
        check("d2_stop2/ovr",   ovr2,   0);
        send2(7'h2A, 1, 0, 0);
        @(negedge clk);
        check("d2_par/perr",  perr2,  1);
        check("d2_par/level", level2, 1);

        // Randomized frames, pops and clears against the model
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            bit fp, bs;
            int npop;
            d    = 8'($urandom);
            fp   = ($urandom_range(0, 5) == 0);
            bs   = ($urandom_range(0, 5) == 0);
            send1(d, fp, bs);
            check_model($sformatf("rnd%0d", n));
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) pop1($sformatf("rnd%0d_p%0d", n, k));
            if ($urandom_range(0, 4) == 0) clear_err();
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        check_model("rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
